// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared register-file definitions for the write-back controller and its port-B queue.
package regfile_wb_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_NUM    = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // Which source drives the write port in a given cycle.
  typedef enum logic [1:0] {
    SRC_IDLE = 2'd0,
    SRC_A    = 2'd1,
    SRC_B    = 2'd2
  } wb_src_e;

  function automatic logic is_writable(input reg_addr_t addr);
    return addr != REG_ZERO;
  endfunction

endpackage

// File: rtl/regfile_wb_ctrl_wb_fifo.sv
// Small synchronous FIFO holding long-latency results {addr, data} until the write port is free.
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 37
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = 1;
  localparam logic [PTR_W:0]   CNT_ONE  = 1;
  localparam logic [PTR_W:0]   CNT_FULL = DEPTH[PTR_W:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; clearing the pointers and count already empties the queue.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file write-back controller: arbitrates ALU (A) and queued long-latency (B) results
// onto one registered write port and tracks pending long-latency destinations.
module regfile_wb_ctrl
  import regfile_wb_ctrl_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [4:0]        a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [4:0]        b_addr,
  input  logic [DATA_W-1:0] b_data,
  input  logic              iss_valid,
  input  logic [4:0]        iss_addr,
  input  logic [4:0]        q_addr1,
  input  logic [4:0]        q_addr2,
  output logic              q_busy1,
  output logic              q_busy2,
  output logic              wen,
  output logic [4:0]        waddr,
  output logic [DATA_W-1:0] wdata
);

  localparam int ENTRY_W = REG_ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = STARVE_MAX[CNT_W-1:0];
  localparam logic [CNT_W-1:0] CNT_ONE    = 1;

  logic [ENTRY_W-1:0] head;
  reg_addr_t          head_addr;
  logic [DATA_W-1:0]  head_data;
  logic               fifo_full;
  logic               fifo_empty;
  logic               a_take;
  logic               b_pop;
  logic               b_push;
  logic [CNT_W-1:0]   starve_cnt;
  logic [REG_NUM-1:0] pend;
  logic [REG_NUM-1:0] set_vec;
  logic [REG_NUM-1:0] clr_vec;
  wb_src_e            sel_src;
  reg_addr_t          sel_addr;
  logic [DATA_W-1:0]  sel_data;

  assign b_ready   = !fifo_full;
  assign b_push    = b_valid && b_ready;
  assign a_ready   = (starve_cnt < STARVE_LIM);
  assign a_take    = a_valid && a_ready;
  assign b_pop     = !a_take && !fifo_empty;
  assign head_addr = head[DATA_W +: REG_ADDR_W];
  assign head_data = head[DATA_W-1:0];

  wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (b_push),
    .pop   (b_pop),
    .din   ({b_addr, b_data}),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sel_src  = SRC_IDLE;
    sel_addr = REG_ZERO;
    sel_data = '0;
    if (a_take) begin
      sel_src  = SRC_A;
      sel_addr = a_addr;
      sel_data = a_data;
    end else if (b_pop) begin
      sel_src  = SRC_B;
      sel_addr = head_addr;
      sel_data = head_data;
    end
  end

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (iss_valid && is_writable(iss_addr)) set_vec[iss_addr]  = 1'b1;
    if (b_pop && is_writable(head_addr))    clr_vec[head_addr] = 1'b1;
  end

  assign q_busy1 = pend[q_addr1];
  assign q_busy2 = pend[q_addr2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
      pend       <= '0;
      wen        <= 1'b0;
      waddr      <= REG_ZERO;
      wdata      <= '0;
    end else begin
      // Age only while a queued B result is being passed over by A.
      if (fifo_empty || b_pop) starve_cnt <= '0;
      else                     starve_cnt <= starve_cnt + CNT_ONE;

      // Applying the set after the clear makes a same-address issue win over a commit.
      pend <= (pend & ~clr_vec) | set_vec;

      wen <= (sel_src != SRC_IDLE) && is_writable(sel_addr);
      if (sel_src != SRC_IDLE) begin
        waddr <= sel_addr;
        wdata <= sel_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl: arbitration, starvation, FIFO full, scoreboard, r0 and reset.
module tb_regfile_wb_ctrl;

  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              a_valid;
  logic              a_ready;
  logic [4:0]        a_addr;
  logic [DATA_W-1:0] a_data;
  logic              b_valid;
  logic              b_ready;
  logic [4:0]        b_addr;
  logic [DATA_W-1:0] b_data;
  logic              iss_valid;
  logic [4:0]        iss_addr;
  logic [4:0]        q_addr1;
  logic [4:0]        q_addr2;
  logic              q_busy1;
  logic              q_busy2;
  logic              wen;
  logic [4:0]        waddr;
  logic [DATA_W-1:0] wdata;

  int checks = 0;
  int errors = 0;

  regfile_wb_ctrl #(
    .DEPTH      (4),
    .STARVE_MAX (3),
    .DATA_W     (DATA_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_addr    (a_addr),
    .a_data    (a_data),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_addr    (b_addr),
    .b_data    (b_data),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .q_addr1   (q_addr1),
    .q_addr2   (q_addr2),
    .q_busy1   (q_busy1),
    .q_busy2   (q_busy2),
    .wen       (wen),
    .waddr     (waddr),
    .wdata     (wdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_valid   = 1'b0;
    a_addr    = '0;
    a_data    = '0;
    b_valid   = 1'b0;
    b_addr    = '0;
    b_data    = '0;
    iss_valid = 1'b0;
    iss_addr  = '0;
  endtask

  task automatic test_reset();
    idle();
    q_addr1 = 5'd9;
    q_addr2 = 5'd0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({wen, waddr, wdata} !== {1'b0, 5'd0, 32'h0}) begin
      errors++;
      $display("FAIL reset_out: got wen=%0b waddr=%0d wdata=%h, expected 0/0/0", wen, waddr, wdata);
    end
    checks++;
    if ({a_ready, b_ready} !== 2'b11) begin
      errors++;
      $display("FAIL reset_ready: got a_ready=%0b b_ready=%0b, expected 1/1", a_ready, b_ready);
    end
    checks++;
    if ({q_busy1, q_busy2} !== 2'b00) begin
      errors++;
      $display("FAIL reset_busy: got %b, expected 00", {q_busy1, q_busy2});
    end
  endtask

  task automatic test_a_only();
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h1234;
    #1;
    checks++;
    if (a_ready !== 1'b1) begin
      errors++;
      $display("FAIL a_only_ready: got %0b, expected 1", a_ready);
    end
    tick();
    idle();
    checks++;
    if ({wen, waddr, wdata} !== {1'b1, 5'd5, 32'h1234}) begin
      errors++;
      $display("FAIL a_only_write: got wen=%0b waddr=%0d wdata=%h, expected 1/5/1234", wen, waddr, wdata);
    end
    tick();
    checks++;
    if (wen !== 1'b0) begin
      errors++;
      $display("FAIL a_only_release: got wen=%0b, expected 0", wen);
    end
  endtask

  task automatic test_collide();
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h11;
    b_valid = 1'b1; b_addr = 5'd7; b_data = 32'hAA;
    tick();
    idle();
    checks++;
    if ({wen, waddr, wdata} !== {1'b1, 5'd3, 32'h11}) begin
      errors++;
      $display("FAIL collide_first: got wen=%0b waddr=%0d wdata=%h, expected 1/3/11", wen, waddr, wdata);
    end
    tick();
    checks++;
    if ({wen, waddr, wdata} !== {1'b1, 5'd7, 32'hAA}) begin
      errors++;
      $display("FAIL collide_second: got wen=%0b waddr=%0d wdata=%h, expected 1/7/aa", wen, waddr, wdata);
    end
    tick();
    checks++;
    if (wen !== 1'b0) begin
      errors++;
      $display("FAIL collide_idle: got wen=%0b, expected 0", wen);
    end
  endtask

  task automatic test_starvation();
    b_valid = 1'b1; b_addr = 5'd12; b_data = 32'hBB;
    for (int i = 0; i < 4; i++) begin
      a_valid = 1'b1; a_addr = 5'd11; a_data = 32'h100 + i;
      #1;
      checks++;
      if (a_ready !== 1'b1) begin
        errors++;
        $display("FAIL starve_ready_%0d: got a_ready=%0b, expected 1", i, a_ready);
      end
      tick();
      b_valid = 1'b0;
      checks++;
      if ({wen, waddr, wdata} !== {1'b1, 5'd11, 32'h100 + i}) begin
        errors++;
        $display("FAIL starve_a_%0d: got wen=%0b waddr=%0d wdata=%h, expected 1/11/%h",
                 i, wen, waddr, wdata, 32'h100 + i);
      end
    end
    a_data = 32'h104;
    #1;
    checks++;
    if (a_ready !== 1'b0) begin
      errors++;
      $display("FAIL starve_throttle: got a_ready=%0b, expected 0", a_ready);
    end
    tick();
    checks++;
    if ({wen, waddr, wdata} !== {1'b1, 5'd12, 32'hBB}) begin
      errors++;
      $display("FAIL starve_b_write: got wen=%0b waddr=%0d wdata=%h, expected 1/12/bb", wen, waddr, wdata);
    end
    #1;
    checks++;
    if (a_ready !== 1'b1) begin
      errors++;
      $display("FAIL starve_release: got a_ready=%0b, expected 1", a_ready);
    end
    tick();
    idle();
    checks++;
    if ({wen, waddr, wdata} !== {1'b1, 5'd11, 32'h104}) begin
      errors++;
      $display("FAIL starve_held_a: got wen=%0b waddr=%0d wdata=%h, expected 1/11/104", wen, waddr, wdata);
    end
    tick();
  endtask

  task automatic test_full_fifo();
    for (int i = 0; i < 4; i++) begin
      a_valid = 1'b1; a_addr = 5'd1; a_data = i;
      b_valid = 1'b1; b_addr = 5'd20 + 5'(i); b_data = 32'hB0 + i;
      #1;
      checks++;
      if (b_ready !== 1'b1) begin
        errors++;
        $display("FAIL full_push_%0d: got b_ready=%0b, expected 1", i, b_ready);
      end
      tick();
    end
    a_data = 32'd4; b_addr = 5'd24; b_data = 32'hB4;
    #1;
    checks++;
    if ({b_ready, a_ready} !== 2'b00) begin
      errors++;
      $display("FAIL full_blocked: got b_ready=%0b a_ready=%0b, expected 0/0", b_ready, a_ready);
    end
    tick();
    checks++;
    if ({wen, waddr, wdata} !== {1'b1, 5'd20, 32'hB0}) begin
      errors++;
      $display("FAIL full_pop0: got wen=%0b waddr=%0d wdata=%h, expected 1/20/b0", wen, waddr, wdata);
    end
    #1;
    checks++;
    if (b_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_reopen: got b_ready=%0b, expected 1", b_ready);
    end
    tick();
    idle();
    checks++;
    if ({wen, waddr, wdata} !== {1'b1, 5'd1, 32'd4}) begin
      errors++;
      $display("FAIL full_a_write: got wen=%0b waddr=%0d wdata=%h, expected 1/1/4", wen, waddr, wdata);
    end
    for (int i = 1; i < 5; i++) begin
      tick();
      checks++;
      if ({wen, waddr, wdata} !== {1'b1, 5'd20 + 5'(i), 32'hB0 + i}) begin
        errors++;
        $display("FAIL full_drain_%0d: got wen=%0b waddr=%0d wdata=%h, expected 1/%0d/%h",
                 i, wen, waddr, wdata, 20 + i, 32'hB0 + i);
      end
    end
    tick();
    checks++;
    if (wen !== 1'b0) begin
      errors++;
      $display("FAIL full_empty: got wen=%0b, expected 0", wen);
    end
  endtask

  task automatic test_scoreboard();
    idle();
    q_addr1 = 5'd9; q_addr2 = 5'd8;
    #1;
    checks++;
    if (q_busy1 !== 1'b0) begin
      errors++;
      $display("FAIL sb_legal_issue: got q_busy1=%0b before issue, expected 0", q_busy1);
    end
    iss_valid = 1'b1; iss_addr = 5'd9;
    #1;
    checks++;
    if (q_busy1 !== 1'b0) begin
      errors++;
      $display("FAIL sb_no_bypass: got q_busy1=%0b, expected 0", q_busy1);
    end
    tick();
    iss_valid = 1'b0;
    #1;
    checks++;
    if ({q_busy1, q_busy2} !== 2'b10) begin
      errors++;
      $display("FAIL sb_set: got busy1/2=%b, expected 10", {q_busy1, q_busy2});
    end
    b_valid = 1'b1; b_addr = 5'd9; b_data = 32'h99;
    tick();
    b_valid = 1'b0;
    #1;
    checks++;
    if (q_busy1 !== 1'b1) begin
      errors++;
      $display("FAIL sb_pop_cycle: got q_busy1=%0b, expected 1", q_busy1);
    end
    tick();
    checks++;
    if ({wen, waddr, wdata, q_busy1} !== {1'b1, 5'd9, 32'h99, 1'b0}) begin
      errors++;
      $display("FAIL sb_clear: got wen=%0b waddr=%0d wdata=%h busy=%0b, expected 1/9/99/0",
               wen, waddr, wdata, q_busy1);
    end
    iss_valid = 1'b1; iss_addr = 5'd9;
    tick();
    iss_valid = 1'b0;
    b_valid = 1'b1; b_addr = 5'd9; b_data = 32'h55;
    tick();
    b_valid = 1'b0;
    iss_valid = 1'b1; iss_addr = 5'd9;
    tick();
    iss_valid = 1'b0;
    checks++;
    if ({wen, waddr, wdata, q_busy1, q_busy2} !== {1'b1, 5'd9, 32'h55, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL sb_set_wins: got wen=%0b waddr=%0d wdata=%h busy1=%0b busy2=%0b, expected 1/9/55/1/0",
               wen, waddr, wdata, q_busy1, q_busy2);
    end
    b_valid = 1'b1; b_addr = 5'd9; b_data = 32'h66;
    tick();
    idle();
    tick();
    checks++;
    if ({wdata, q_busy1} !== {32'h66, 1'b0}) begin
      errors++;
      $display("FAIL sb_final_clear: got wdata=%h busy=%0b, expected 66/0", wdata, q_busy1);
    end
  endtask

  task automatic test_r0_reset();
    a_valid = 1'b1; a_addr = 5'd0; a_data = 32'hDEAD;
    tick();
    idle();
    checks++;
    if (wen !== 1'b0) begin
      errors++;
      $display("FAIL r0_a_write: got wen=%0b, expected 0", wen);
    end
    q_addr1 = 5'd0;
    iss_valid = 1'b1; iss_addr = 5'd0;
    tick();
    iss_valid = 1'b0;
    checks++;
    if (q_busy1 !== 1'b0) begin
      errors++;
      $display("FAIL r0_busy: got q_busy1=%0b, expected 0", q_busy1);
    end
    b_valid = 1'b1; b_addr = 5'd0; b_data = 32'hBEEF;
    tick();
    b_valid = 1'b0;
    tick();
    checks++;
    if ({wen, b_ready} !== 2'b01) begin
      errors++;
      $display("FAIL r0_b_write: got wen=%0b b_ready=%0b, expected 0/1", wen, b_ready);
    end
    iss_valid = 1'b1; iss_addr = 5'd4;
    tick();
    iss_addr = 5'd5;
    tick();
    iss_valid = 1'b0;
    q_addr1 = 5'd4; q_addr2 = 5'd5;
    for (int i = 0; i < 3; i++) begin
      a_valid = 1'b1; a_addr = 5'd2; a_data = 32'h200 + i;
      b_valid = 1'b1; b_addr = 5'd16 + 5'(i); b_data = 32'hC0 + i;
      tick();
    end
    idle();
    checks++;
    if ({wen, q_busy1, q_busy2} !== 3'b111) begin
      errors++;
      $display("FAIL pre_reset: got wen/busy1/busy2=%b, expected 111", {wen, q_busy1, q_busy2});
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({wen, waddr, wdata, q_busy1, q_busy2, a_ready, b_ready} !== {1'b0, 5'd0, 32'h0, 4'b0011}) begin
      errors++;
      $display("FAIL mid_reset: got wen=%0b waddr=%0d wdata=%h busy=%b ready=%b, expected 0/0/0/00/11",
               wen, waddr, wdata, {q_busy1, q_busy2}, {a_ready, b_ready});
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (wen !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_%0d: got wen=%0b, expected 0 (queue must be empty)", i, wen);
      end
    end
  endtask

  initial begin
    test_reset();
    test_a_only();
    test_collide();
    test_starvation();
    test_full_fifo();
    test_scoreboard();
    test_r0_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
